// File: rtl/lio_ahb2axil_pkg.sv
// lio_ahb2axil_pkg: shared FSM states and AHB/AXI encodings for the AHB-Lite to AXI-Lite bridge.
package lio_ahb2axil_pkg;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ERR1, ERR2} state_e;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
endpackage

// File: rtl/lio_ahb_wstrb_gen.sv
// lio_ahb_wstrb_gen: byte-lane strobes from AHB transfer size and low address bits.
module lio_ahb_wstrb_gen
  import lio_ahb2axil_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] wstrb_o
);
  always_comb wstrb_o = hsize_i == HSIZE_BYTE ? 4'b0001 << addr_i :
                        hsize_i == HSIZE_HALF ? (addr_i[1] ? 4'hC : 4'h3) : 4'hF;
endmodule

// File: rtl/lio_ahb2axil.sv
// lio_ahb2axil: AHB-Lite slave to AXI-Lite master bridge, one outstanding transfer,
// AXI SLVERR/DECERR returned as the two-cycle AHB ERROR response.
module lio_ahb2axil
  import lio_ahb2axil_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hsel,
  input  logic [AWIDTH-1:0]   haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [DWIDTH-1:0]   hwdata,
  input  logic                hready,
  output logic                hreadyout,
  output logic [DWIDTH-1:0]   hrdata,
  output logic                hresp,
  output logic [AWIDTH-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DWIDTH-1:0]   wdata,
  output logic [DWIDTH/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [AWIDTH-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DWIDTH-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);
  state_e state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [2:0] hsize_q, hsize_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, hrdata_q, hrdata_d;
  logic hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic accept, b_err, r_err;
  assign accept = hsel & hready & !(htrans inside {HTRANS_IDLE, HTRANS_BUSY});
  assign b_err = !(bresp inside {AXI_RESP_OKAY, AXI_RESP_EXOKAY});
  assign r_err = !(rresp inside {AXI_RESP_OKAY, AXI_RESP_EXOKAY});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      hsize_q <= HSIZE_WORD;
      wdata_q <= '0;
      hrdata_q <= '0;
      hreadyout_q <= 1'b1;
      hresp_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      hsize_q <= hsize_d;
      wdata_q <= wdata_d;
      hrdata_q <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q <= hresp_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    hsize_d = hsize_q;
    wdata_d = wdata_q;
    hrdata_d = hrdata_q;
    hreadyout_d = hreadyout_q;
    hresp_d = hresp_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    case (state_q)
      IDLE, ERR2: begin
        hresp_d = 1'b0;
        hreadyout_d = !accept;
        addr_d = accept ? haddr : addr_q;
        hsize_d = accept ? hsize : hsize_q;
        arvalid_d = accept & !hwrite;
        state_d = !accept ? IDLE : hwrite ? WR_DATA : RD_REQ;
      end
      WR_DATA: begin
        wdata_d = hwdata;
        awvalid_d = 1'b1;
        wvalid_d = 1'b1;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        // each channel retires on its own handshake; response phase waits for both
        awvalid_d = awvalid_q & !awready;
        wvalid_d = wvalid_q & !wready;
        bready_d = !awvalid_d & !wvalid_d;
        state_d = bready_d ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (bvalid) begin
        bready_d = 1'b0;
        hresp_d = b_err;
        hreadyout_d = !b_err;
        state_d = b_err ? ERR1 : IDLE;
      end
      RD_REQ: if (arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_RESP;
      end
      RD_RESP: if (rvalid) begin
        hrdata_d = rdata;
        rready_d = 1'b0;
        hresp_d = r_err;
        hreadyout_d = !r_err;
        state_d = r_err ? ERR1 : IDLE;
      end
      ERR1: begin
        hreadyout_d = 1'b1;
        state_d = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end
  lio_ahb_wstrb_gen u_wstrb (.hsize_i(hsize_q), .addr_i(addr_q[1:0]), .wstrb_o(wstrb));
  assign hreadyout = hreadyout_q;
  assign hresp = hresp_q;
  assign hrdata = hrdata_q;
  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign awprot = 3'b000;
  assign arprot = 3'b000;
  assign wdata = wdata_q;
  assign awvalid = awvalid_q;
  assign wvalid = wvalid_q;
  assign bready = bready_q;
  assign arvalid = arvalid_q;
  assign rready = rready_q;
endmodule

// File: doc/lio_ahb2axil.md
LIO_AHB2AXIL -- requirements
Module: lio_ahb2axil

Interface
REQ-001 SHALL have parameter AWIDTH, default 16: address width on both sides.
REQ-002 SHALL have parameter DWIDTH, default 32: data width; only 32 is supported.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have these AHB-Lite slave ports:
- hsel  in  1  slave select.
- haddr  in  AWIDTH  address.
- htrans  in  2  transfer type.
- hwrite  in  1  write transfer.
- hsize  in  3  transfer size.
- hwdata  in  DWIDTH  write data.
- hready  in  1  bus ready.
- hreadyout  out  1  slave ready.
- hrdata  out  DWIDTH  read data.
- hresp  out  1  0=OKAY, 1=ERROR.
REQ-005 SHALL have these AXI-Lite master ports, standard meanings:
- awaddr  out  AWIDTH.
- awprot  out  3.
- awvalid  out  1.
- awready  in  1.
- wdata  out  DWIDTH.
- wstrb  out  DWIDTH/8.
- wvalid  out  1.
- wready  in  1.
- bresp  in  2.
- bvalid  in  1.
- bready  out  1.
- araddr  out  AWIDTH.
- arprot  out  3.
- arvalid  out  1.
- arready  in  1.
- rdata  in  DWIDTH.
- rresp  in  2.
- rvalid  in  1.
- rready  out  1.

Function
REQ-006 SHALL use the states IDLE, WR_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ERR1 and ERR2.
REQ-007 Address phase SHALL be accepted in IDLE or ERR2 when hsel & htrans[1] & hready = 1. The block SHALL then register haddr, hwrite and hsize, and drive hreadyout <= 0 in the next cycle.
REQ-008 IDLE/BUSY transfers (htrans[1]=0) and cycles with hsel=0 SHALL be ignored. hreadyout SHALL stay 1 and hresp SHALL stay 0.
REQ-009 Write accept SHALL go to WR_DATA. In WR_DATA the block SHALL capture hwdata into wdata, set awvalid=wvalid=1 and go to WR_REQ. Valids therefore appear 2 cycles after the address phase.
REQ-010 In WR_REQ, awvalid and wvalid SHALL each clear independently on their own handshake, including when both handshakes happen in the same cycle. Once both are done, the block SHALL set bready=1 and go to WR_RESP.
REQ-011 In WR_RESP, bvalid SHALL clear bready.
- bresp[1]=0: hreadyout <= 1, go to IDLE.
- bresp[1]=1: go to ERR1.
REQ-012 Read accept SHALL go to RD_REQ with arvalid=1 one cycle after the address phase. arready SHALL clear arvalid, set rready=1 and go to RD_RESP.
REQ-013 In RD_RESP, rvalid SHALL register rdata into hrdata and clear rready.
- rresp[1]=0: hreadyout <= 1, go to IDLE.
- rresp[1]=1: go to ERR1.
REQ-014 ERR1 SHALL drive hresp=1 and hreadyout=0. ERR2 SHALL drive hresp=1 and hreadyout=1, then go to IDLE, or accept a new transfer per REQ-007. This is the two-cycle AHB error response.
REQ-015 awaddr and araddr SHALL equal the registered haddr.
REQ-016 awprot and arprot SHALL be 3'b000.
REQ-017 wstrb SHALL be decoded from the registered hsize and haddr[1:0]:
- hsize=0: 4'b0001 << haddr[1:0].
- hsize=1: 4'hC if haddr[1]=1, else 4'h3.
- hsize >= 2: 4'hF.
REQ-018 The block SHALL keep only one outstanding AXI transaction, with no pipelining. bvalid or rvalid outside their wait states SHALL be ignored.
REQ-019 An AXI handshake response with OKAY (0) or EXOKAY (1) SHALL map to AHB OKAY. SLVERR (2) and DECERR (3) SHALL map to AHB ERROR.

Reset
REQ-020 Asserting rst_n low SHALL immediately force:
- state=IDLE;
- hreadyout=1, hresp=0, hrdata=0;
- awvalid, wvalid, bready, arvalid, rready = 0;
- awaddr, araddr, wdata = 0;
- wstrb=4'hF.
REQ-021 Reset during any in-flight transfer SHALL abandon it without completing the AXI handshake. After release, the block SHALL be in IDLE.

Structure
REQ-022 Package lio_ahb2axil_pkg SHALL hold the state enum, HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD and the AXI_RESP_* constants.
REQ-023 Combinational sub-module lio_ahb_wstrb_gen SHALL implement REQ-017.

Verification
REQ-024 Word write to 0x0010 with data 0xA5A55A5A:
- awaddr=0x0010, wdata=0xA5A55A5A, wstrb=4'hF.
- With awready=wready=1 and bvalid one cycle later, hreadyout returns to 1 four cycles after the address phase.
REQ-025 Byte write to 0x0003 and halfword write to 0x0002 -> wstrb=4'h8 and wstrb=4'hC.
REQ-026 Read from 0x0020, arready delayed 3 cycles, rdata=0x12345678 -> hrdata=0x12345678, hresp=0, and arvalid held high until the handshake.
REQ-027 Write with awready before wready (AW at cycle 1, W at cycle 4) -> exactly one handshake per channel, and bready only after both.
REQ-028 Read with rresp=2'b10 -> hresp=1 for two cycles, hreadyout pattern 0 then 1, followed by a back-to-back NONSEQ in ERR2 that is accepted.
REQ-029 rst_n low while in WR_REQ -> all valids 0 and hreadyout=1 asynchronously; the next transfer completes normally.
